elastic_pipe_reg: RTL and testbench
===================================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001: Parameter WIDTH, default 8, payload width in bits; SHALL be >= 1.
REQ-002: Parameter DEPTH, default 2, number of register stages; SHALL be >= 1.
REQ-003: Parameter OCC_W, default $clog2(DEPTH+1), occupancy count width.
REQ-004: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: in_valid  input  1  upstream payload valid.
REQ-007: in_ready  output  1  block can accept the input this cycle.
REQ-008: in_data  input  WIDTH  upstream payload.
REQ-009: out_valid  output  1  output payload valid.
REQ-010: out_ready  input  1  downstream accepts the output this cycle.
REQ-011: out_data  output  WIDTH  output payload (last stage).
REQ-012: occupancy  output  OCC_W  number of stages currently holding valid data.

Function
REQ-013: Each stage k (0..DEPTH-1) SHALL hold a data register and a valid bit; stage 0 faces input, stage DEPTH-1 drives out_data/out_valid.
REQ-014: Stage ready SHALL be rdy[k] = !valid[k] | rdy[k+1], with rdy[DEPTH] = out_ready (bubble-collapsing, combinational chain).
REQ-015: in_ready SHALL equal rdy[0]; a transfer occurs when valid & ready are both 1 on the same edge.
REQ-016: On an edge where rdy[k] = 1, stage k SHALL load stage k-1's data/valid (stage 0 loads in_data/in_valid); where rdy[k] = 0 it SHALL hold.
REQ-017: Latency SHALL be exactly DEPTH cycles from input transfer to out_valid with no stalls; throughput one beat per cycle.
REQ-018: While out_valid = 1 and out_ready = 0, out_data and out_valid SHALL remain stable until transfer.
REQ-019: Data SHALL emerge in acceptance order; no beat is dropped or duplicated.
REQ-020: Full (all valid, out_ready = 0): in_ready = 0; inputs presented are not accepted.
REQ-021: Full with out_ready = 1: in_ready = 1; one beat out and one in on the same edge; occupancy unchanged.
REQ-022: Empty: out_valid = 0; out_data holds the last value and is don't-care to consumers.
REQ-023: A bubble (invalid stage) SHALL be filled on the next edge even if downstream is stalled.
REQ-024: occupancy SHALL equal the popcount of valid[] as registered state (updates the edge after a transfer).
REQ-025: in_data SHALL be ignored when in_valid = 0 (stage 0 valid loads 0).

Reset
REQ-026: Asserting reset SHALL immediately (asynchronously) clear all valid bits and data registers to 0.
REQ-027: During reset: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 0.
REQ-028: Reset asserted mid-stream SHALL discard all in-flight beats; first edge after deassertion behaves as empty pipe.

Configuration
REQ-029: Macro ELASTIC_PIPE_REG_FLUSH_EN SHALL, when defined, add port flush (input, 1): synchronous clear of all valid bits on the next edge, data retained.
REQ-030: With flush = 1: in_ready = 0, no input accepted, out_valid follows current state that cycle but no output transfer is counted; occupancy = 0 after the edge.
REQ-031: Without ELASTIC_PIPE_REG_FLUSH_EN: no flush port exists; behaviour as REQ-013..REQ-028 only.

Verification
REQ-032: WIDTH=8, DEPTH=3, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_valid rises 3 cycles after first accept, outputs 0x11,0x22,0x33 back-to-back.
REQ-033: out_ready=0, send 4 beats 0xA0..0xA3 -> first 3 accepted, in_ready=0 on 4th, occupancy=3, out_data=0xA0 stable; raise out_ready -> 0xA0..0xA3 in order.
REQ-034: Full pipe, in_valid=1, out_ready=1 for 5 cycles -> 5 in, 5 out, occupancy stays 3.
REQ-035: Stage-1 bubble with out_ready=0 -> bubble collapses next edge, occupancy increments by 1 per accepted beat.
REQ-036: Assert reset asynchronously mid-clock with occupancy=2 -> out_valid=0, occupancy=0 before next edge; post-reset send 0x5A -> 0x5A out after 3 cycles.
REQ-037: With ELASTIC_PIPE_REG_FLUSH_EN, occupancy=3, flush=1 with in_valid=1 -> in_ready=0, occupancy=0 next edge, no beat later emerges.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg
//   A chain of DEPTH register stages. The ready chain collapses bubbles, so a
//   stage that holds no data always takes new data, even when the output is
//   stalled. With no stalls the pipe moves one beat per cycle, and each beat
//   takes exactly DEPTH cycles to pass through.
//
// Handshake (both sides): a beat moves on a rising edge where valid and ready
//   are both 1. A producer holds valid and data steady until it sees ready.
//   While out_valid=1 and out_ready=0, out_valid and out_data do not change.
//
// Optional feature: define ELASTIC_PIPE_REG_FLUSH_EN to add the flush input.
//   flush=1 clears every valid bit on the next edge and keeps the data
//   registers as they are. It also blocks input acceptance in that cycle.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high; clears valid bits, data and occupancy
//   flush      (ELASTIC_PIPE_REG_FLUSH_EN only) synchronous clear of valid bits
//   in_valid   upstream payload valid
//   in_ready   pipe can accept in_data this cycle
//   in_data    upstream payload, WIDTH bits
//   out_valid  last stage holds a valid beat
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage payload, WIDTH bits
//   occupancy  registered count of stages holding a valid beat
module elastic_pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef ELASTIC_PIPE_REG_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             flush_w;

`ifdef ELASTIC_PIPE_REG_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Stage k is ready if it is empty or if everything downstream of it is
    // ready. The chain is combinational from out_ready back to stage 0.
    always_comb begin : ready_chain
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r      = ~valid_q[k] | r;
            rdy[k] = r;
        end
    end

    // Upstream view of each stage: stage 0 sees the input port, and every
    // other stage sees the stage before it.
    always_comb begin
        up_valid    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            up_data[k] = '0;
        end
        up_valid[0] = in_valid;
        up_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid[k] = valid_q[k - 1];
            up_data[k]  = data_q[k - 1];
        end
    end

    // A ready stage always takes the upstream valid bit. It takes the
    // upstream data only when that data is valid. Because of this, an
    // emptied pipe still shows the last beat on out_data, and in_data is
    // ignored while in_valid is 0.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
        end
        if (flush_w) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_d[k] = up_valid[k];
                    if (up_valid[k]) begin
                        data_d[k] = up_data[k];
                    end
                end
            end
        end
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // in_ready is forced low during reset and during flush. Without this,
    // the cleared valid bits would make the ready chain read as 1.
    assign in_ready  = rdy[0] & ~flush_w & ~reset;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Testbench for elastic_pipe_reg with WIDTH=8 and DEPTH=3.
//
// Reference model: each accepted beat is kept in a queue, in order, with its
// current stage position. On each edge a beat moves forward in one of two
// cases. Either out_ready is 1, or there are fewer beats ahead of it than
// there are stages ahead of it. From this model the bench derives, for every
// cycle, the expected in_ready, out_valid, out_data and occupancy.
// The scoreboard queue exp_q receives each accepted beat. A separate monitor
// pops exp_q whenever the DUT completes an output transfer.
module tb_elastic_pipe_reg;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } beat_t;

    beat_t            mq[$];
    logic [WIDTH-1:0] exp_q[$];

    elastic_pipe_reg #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef ELASTIC_PIPE_REG_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The reference model decides whether the current cycle accepts a beat.
    function automatic logic model_in_ready();
        return !reset && !flush && ((mq.size() < DEPTH) || out_ready);
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge and stay constant for
    // one full cycle.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic r);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = r;
            done      = model_in_ready();
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got not accepted expected accepted data %0h", d);
        end
    endtask

    // ---------------- reference model + per-cycle checks ----------------
    always @(negedge clk) begin : model
        logic exp_ov;
        logic exp_rdy;
        beat_t b;
        if (reset) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_occupancy", 32'(occupancy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            mq.delete();
            exp_q.delete();
        end else begin
            exp_rdy = model_in_ready();
            exp_ov  = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("occupancy", 32'(occupancy), 32'(mq.size()));
            if (exp_ov) begin
                check("out_data_head", 32'(out_data), 32'(mq[0].data));
            end
            if (flush) begin
                mq.delete();
                exp_q.delete();
            end else begin
                for (int i = 0; i < mq.size(); i++) begin
                    b = mq[i];
                    if (b.pos < DEPTH - 1 && (out_ready || i < DEPTH - 1 - b.pos)) begin
                        b.pos = b.pos + 1;
                        mq[i] = b;
                    end
                end
                if (exp_ov && out_ready) begin
                    void'(mq.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    b.data = in_data;
                    b.pos  = 0;
                    mq.push_back(b);
                    exp_q.push_back(in_data);
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [WIDTH-1:0] e;
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_unexpected: got %0h expected no beat", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data_order", 32'(out_data), 32'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Three beats sent back to back with no stalls.
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        repeat (5) step(1'b0, 8'h00, 1'b1);

        // Pipe fills with the output stalled, then drains in order.
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        repeat (3) step(1'b1, 8'hA3, 1'b0);
        send(8'hA3, 1'b1);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Full pipe passing beats through: one in and one out per cycle.
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(8'hD0 + 8'(i), 1'b1);
        end
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // A bubble in stage 1 collapses while the output is stalled.
        send(8'hE0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        send(8'hE1, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        send(8'hE2, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset asserted mid-cycle with two beats in flight.
        send(8'hB0, 1'b0);
        send(8'hB1, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_occupancy", 32'(occupancy), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        send(8'h5A, 1'b1);
        repeat (5) step(1'b0, 8'h00, 1'b1);

`ifdef ELASTIC_PIPE_REG_FLUSH_EN
        // Flush of a full pipe while a new input is offered.
        send(8'hF0, 1'b0);
        send(8'hF1, 1'b0);
        send(8'hF2, 1'b0);
        flush = 1'b1;
        step(1'b1, 8'hFF, 1'b1);
        flush = 1'b0;
        repeat (6) step(1'b0, 8'h00, 1'b1);
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 70),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) < 60));
        end
        repeat (DEPTH + 3) step(1'b0, 8'h00, 1'b1);

        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
